// File: rtl/cache_controller.sv
// Direct-mapped 64 x 32-bit write-through, no-allocate cache in front of an SRAM controller.
// Optional load-hit counter: define CACHE_HIT_COUNTER_EN to build it, otherwise hit_count is 0.
module cache_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_r_en,
    output logic        sram_w_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready,
    output logic [31:0] hit_count
);
    // Handshake: a request is held stable while ready=0; ready=1 in a cycle with a
    // request means it completes at the next rising edge and the pipeline may advance.
    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, DONE} state_t;

    state_t      state;
    logic        seen_busy;
    logic        last_read;
    logic [31:0] fill;
    logic [63:0] valid;
    logic [9:0]  tag_mem  [0:63];
    logic [31:0] data_mem [0:63];

    logic [5:0]  idx;
    logic [9:0]  tag;
    logic        hit;
    logic        done_now;
    logic        unused_addr_bits;

    assign idx              = address[7:2];
    assign tag              = address[17:8];
    assign hit              = valid[idx] && (tag_mem[idx] == tag);
    assign done_now         = sram_ready && seen_busy;
    assign sram_address     = address;
    assign sram_wdata       = wdata;
    assign unused_addr_bits = ^{address[31:18], address[1:0]};

    always_comb begin
        ready = 1'b1;
        rdata = 32'd0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (MEM_W_EN) begin
                        ready = 1'b0;
                    end else if (MEM_R_EN) begin
                        ready = hit;
                        rdata = hit ? data_mem[idx] : 32'd0;
                    end
                end
                RD_MISS, WR_THRU: ready = 1'b0;
                DONE:             rdata = last_read ? fill : 32'd0;
                default:          ready = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            seen_busy <= 1'b0;
            last_read <= 1'b0;
            fill      <= 32'd0;
            valid     <= 64'd0;
            sram_r_en <= 1'b0;
            sram_w_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MEM_W_EN) begin
                        state     <= WR_THRU;
                        sram_w_en <= 1'b1;
                        last_read <= 1'b0;
                    end else if (MEM_R_EN && !hit) begin
                        state     <= RD_MISS;
                        sram_r_en <= 1'b1;
                        last_read <= 1'b1;
                    end
                end
                RD_MISS: begin
                    if (done_now) begin
                        state      <= DONE;
                        seen_busy  <= 1'b0;
                        sram_r_en  <= 1'b0;
                        valid[idx] <= 1'b1;
                    end else begin
                        // Keeps the word presented in the cycle before completion.
                        fill <= sram_rdata;
                        if (!sram_ready) seen_busy <= 1'b1;
                    end
                end
                WR_THRU: begin
                    if (done_now) begin
                        state     <= DONE;
                        seen_busy <= 1'b0;
                        sram_w_en <= 1'b0;
                    end else if (!sram_ready) begin
                        seen_busy <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (state == RD_MISS && done_now) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= fill;
        end else if (state == WR_THRU && done_now && hit) begin
            data_mem[idx] <= wdata;
        end
    end

`ifdef CACHE_HIT_COUNTER_EN
    logic [31:0] hit_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt <= 32'd0;
        end else if (state == IDLE && !MEM_W_EN && MEM_R_EN && hit) begin
            hit_cnt <= hit_cnt + 32'd1;
        end
    end

    assign hit_count = hit_cnt;
`else
    assign hit_count = 32'd0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: directed requests push expected responses,
// a negedge monitor pops and compares them when the DUT signals completion.
module tb_cache_controller;
    logic        clk;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ready;
    logic [31:0] hit_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_hits = 0;

    // Entry layout: {stalled, saw_sram_r, saw_sram_w, rdata}
    logic [34:0] exp_q[$];

    logic [31:0] sram_val;
    int          sram_lat;
    int          busy_left;
    logic        started;

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .MEM_R_EN     (mem_r_en),
        .MEM_W_EN     (mem_w_en),
        .address      (address),
        .wdata        (wdata),
        .rdata        (rdata),
        .ready        (ready),
        .sram_r_en    (sram_r_en),
        .sram_w_en    (sram_w_en),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready),
        .hit_count    (hit_count)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_hc();
`ifdef CACHE_HIT_COUNTER_EN
        return exp_hits;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [34:0] mk(input logic stall, input logic r, input logic w,
                                       input logic [31:0] d);
        return {stall, r, w, d};
    endfunction

    // SRAM controller model: busy for sram_lat cycles, sram_val shown in the last busy cycle.
    initial begin
        sram_ready = 1'b1;
        sram_rdata = 32'h0;
        started    = 1'b0;
        busy_left  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!(sram_r_en || sram_w_en)) begin
                started    = 1'b0;
                sram_ready = 1'b1;
            end else if (!started) begin
                started    = 1'b1;
                busy_left  = sram_lat;
                sram_ready = 1'b0;
                sram_rdata = (busy_left == 1) ? sram_val : 32'hBAD0_0001;
            end else if (busy_left > 1) begin
                busy_left  = busy_left - 1;
                sram_ready = 1'b0;
                sram_rdata = (busy_left == 1) ? sram_val : 32'hBAD0_0002;
            end else begin
                sram_ready = 1'b1;
                sram_rdata = 32'hBAD0_0003;
            end
        end
    end

    // Monitor
    logic        mon_stall;
    logic        mon_r;
    logic        mon_w;
    logic [34:0] mon_e;
    initial begin
        mon_stall = 1'b0;
        mon_r     = 1'b0;
        mon_w     = 1'b0;
    end
    always @(negedge clk) begin
        if (!rst) begin
            mon_stall = 1'b0;
            mon_r     = 1'b0;
            mon_w     = 1'b0;
        end else if (mem_r_en || mem_w_en) begin
            if (sram_r_en) mon_r = 1'b1;
            if (sram_w_en) mon_w = 1'b1;
            if (!ready) begin
                mon_stall = 1'b1;
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: got completion at addr %h expected none", address);
            end else begin
                mon_e = exp_q.pop_front();
                check("stalled", {31'd0, mon_stall}, {31'd0, mon_e[34]});
                check("saw_sram_r_en", {31'd0, mon_r}, {31'd0, mon_e[33]});
                check("saw_sram_w_en", {31'd0, mon_w}, {31'd0, mon_e[32]});
                check("rdata", rdata, mon_e[31:0]);
                mon_stall = 1'b0;
                mon_r     = 1'b0;
                mon_w     = 1'b0;
            end
        end
    end

    // Driver tasks
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic w, input logic r, input logic [31:0] addr,
                          input logic [31:0] data, input logic [34:0] exp);
        logic got;
        exp_q.push_back(exp);
        mem_w_en = w;
        mem_r_en = r;
        address  = addr;
        wdata    = data;
        got      = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (ready) got = 1'b1;
        end
        check("completion_in_budget", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        mem_w_en = 1'b0;
        mem_r_en = 1'b0;
    endtask

    task automatic rd_hit(input logic [31:0] addr, input logic [31:0] d);
        exp_hits++;
        do_req(1'b0, 1'b1, addr, 32'd0, mk(1'b0, 1'b0, 1'b0, d));
    endtask

    task automatic rd_miss(input logic [31:0] addr, input logic [31:0] d, input int lat);
        sram_val = d;
        sram_lat = lat;
        do_req(1'b0, 1'b1, addr, 32'd0, mk(1'b1, 1'b1, 1'b0, d));
    endtask

    task automatic wr(input logic r, input logic [31:0] addr, input logic [31:0] d);
        sram_lat = 2;
        do_req(1'b1, r, addr, d, mk(1'b1, 1'b0, 1'b1, 32'd0));
    endtask

    int t0;
    initial begin
        rst      = 1'b0;
        mem_r_en = 1'b1;
        mem_w_en = 1'b0;
        address  = 32'h104;
        wdata    = 32'h0;
        sram_val = 32'h0;
        sram_lat = 2;
        repeat (2) @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_rdata", rdata, 32'd0);
        check("reset_sram_r_en", {31'd0, sram_r_en}, 32'd0);
        check("reset_sram_w_en", {31'd0, sram_w_en}, 32'd0);
        check("reset_hit_count", hit_count, 32'd0);
        mem_r_en = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(2);

        rd_miss(32'h104, 32'hDEADBEEF, 2);
        rd_hit(32'h104, 32'hDEADBEEF);
        check("hit_count_after_first_hit", hit_count, exp_hc());

        wr(1'b0, 32'h104, 32'h12345678);
        rd_hit(32'h104, 32'h12345678);

        wr(1'b0, 32'h208, 32'hCAFEF00D);
        rd_miss(32'h208, 32'hCAFEF00D, 3);

        rd_hit(32'h104, 32'h12345678);
        rd_miss(32'h204, 32'h55AA55AA, 2);
        rd_miss(32'h104, 32'h12345678, 1);

        t0 = cyc;
        rd_hit(32'h208, 32'hCAFEF00D);
        rd_hit(32'h104, 32'h12345678);
        rd_hit(32'h208, 32'hCAFEF00D);
        check("back_to_back_cycles", cyc - t0, 32'd3);
        check("hit_count_before_reset", hit_count, exp_hc());

        wr(1'b1, 32'h30C, 32'h0F0F0F0F);
        rd_miss(32'h30C, 32'h0F0F0F0F, 2);

        sram_val = 32'h77777777;
        sram_lat = 4;
        mem_r_en = 1'b1;
        address  = 32'h40C;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midmiss_reset_sram_r_en", {31'd0, sram_r_en}, 32'd0);
        check("midmiss_reset_ready", {31'd0, ready}, 32'd1);
        check("midmiss_reset_rdata", rdata, 32'd0);
        mem_r_en = 1'b0;
        exp_hits = 0;
        idle(1);
        check("hit_count_after_reset", hit_count, exp_hc());
        rst = 1'b1;
        idle(3);

        rd_miss(32'h40C, 32'h89ABCDEF, 2);
        rd_hit(32'h40C, 32'h89ABCDEF);
        idle(3);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("hit_count_final", hit_count, exp_hc());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 MEM_R_EN  in  1  pipeline load request.
REQ-005 MEM_W_EN  in  1  pipeline store request.
REQ-006 address  in  32  byte address from the ALU; bits [1:0] ignored.
REQ-007 wdata  in  32  store data.
REQ-008 rdata  out  32  load data to the pipeline.
REQ-009 ready  out  1  1 = request complete or no request; 0 = freeze pipeline.
REQ-010 sram_r_en  out  1  read request to the SRAM controller.
REQ-011 sram_w_en  out  1  write request to the SRAM controller.
REQ-012 sram_address  out  32  equals address.
REQ-013 sram_wdata  out  32  equals wdata.
REQ-014 sram_rdata  in  32  read data from the SRAM controller.
REQ-015 sram_ready  in  1  SRAM controller ready.
REQ-016 hit_count  out  32  load-hit counter (see Configuration).

Function
REQ-017 The cache SHALL be direct-mapped with 64 lines of one 32-bit word each: index = address[7:2], tag = address[17:8] (10 bits), one valid bit per line.
REQ-018 The FSM SHALL have the states IDLE, RD_MISS, WR_THRU and DONE.
REQ-019 IDLE transitions:
- MEM_W_EN=1 -> WR_THRU.
- else MEM_R_EN=1 with a miss -> RD_MISS.
- else stay in IDLE.
REQ-020 When MEM_W_EN and MEM_R_EN are both 1, the request SHALL be treated as a write.
REQ-021 A read hit in IDLE SHALL give ready=1 and rdata=line data combinationally in the same cycle (zero-cycle latency), with no SRAM access.
REQ-022 In IDLE with no request, ready SHALL be 1 and rdata SHALL be 0.
REQ-023 A read miss or any write in IDLE SHALL drive ready=0 combinationally in the same cycle.
REQ-024 RD_MISS and WR_THRU SHALL hold ready=0, and SHALL assert sram_r_en or sram_w_en respectively as Moore outputs.
REQ-025 In RD_MISS and WR_THRU, a seen_busy flag SHALL set on any cycle with sram_ready=0.
REQ-026 Completion SHALL be the first cycle with sram_ready=1 and seen_busy=1; at that edge:
- the FSM SHALL go to DONE;
- seen_busy SHALL clear;
- the SRAM enable SHALL drop.
REQ-027 A sram_ready=1 seen before any busy cycle SHALL be ignored.
REQ-028 In RD_MISS, a fill register SHALL load sram_rdata on every cycle except the completion cycle, so that it holds the data presented in the cycle before completion.
REQ-029 Read completion SHALL write the fill register, the tag and valid=1 into the indexed line.
REQ-030 Writes SHALL be write-through, no-allocate: on write completion, a line whose valid bit is set and whose tag matches SHALL be updated with wdata; otherwise the cache SHALL be unchanged.
REQ-031 DONE SHALL drive ready=1 and SHALL go to IDLE unconditionally.
REQ-032 In DONE, rdata SHALL equal the fill register after a read and 0 after a write.
REQ-033 The pipeline SHALL hold address, wdata and the enables stable while ready=0; the block SHALL NOT re-sample them outside IDLE.
REQ-034 Back-to-back hits SHALL complete one per cycle.

Reset
REQ-035 When rst=0, the block SHALL asynchronously:
- clear all valid bits, the fill register, seen_busy and hit_count;
- set the FSM to IDLE and sram_r_en=sram_w_en=0.
REQ-036 When rst=0, ready SHALL be 1 and rdata SHALL be 0.
REQ-037 A reset during RD_MISS or WR_THRU SHALL abandon the access without updating any cache line.
REQ-038 Tag and data arrays SHALL need no reset.

Configuration
REQ-039 With CACHE_HIT_COUNTER_EN defined, hit_count SHALL increment by 1, wrapping modulo 2^32, for each read hit accepted in IDLE.
REQ-040 Without CACHE_HIT_COUNTER_EN, hit_count SHALL be tied to 0 and the counter logic SHALL be absent.

Verification
REQ-041 Read miss after reset:
- stimulus: MEM_R_EN=1, address=0x104; the SRAM model returns 0xDEADBEEF in its last busy cycle.
- response: sram_r_en=1 until completion; DONE with ready=1 and rdata=0xDEADBEEF.
REQ-042 Read hit on refill:
- stimulus: repeat the read of 0x104.
- response: same-cycle ready=1, rdata=0xDEADBEEF, sram_r_en never asserted, hit_count=1 with the macro.
REQ-043 Write hit, then read:
- stimulus: write 0x12345678 to 0x104, then read 0x104.
- response: sram_w_en pulse covers the busy period; the read hits with 0x12345678.
- stimulus: write to 0x208, then read 0x208.
- response: no allocate; the read misses.
REQ-044 Conflict miss:
- stimulus: read 0x104, then read 0x204 (same index 1, different tag).
- response: the second read misses; a following read of 0x104 misses again.
REQ-045 Simultaneous MEM_R_EN=1 and MEM_W_EN=1 -> write path only: sram_w_en=1, sram_r_en=0, no line fill.
REQ-046 Reset mid-miss:
- stimulus: rst=0 during RD_MISS.
- response: sram_r_en=0 and ready=1 immediately; a later read of the same address misses.
